psg_env_seq: RTL and testbench

PSG_ENV_SEQ -- requirements
Module: psg_env_seq

---
 rtl/psg_pkg.sv | 17 +
 rtl/psg_env_presc.sv | 30 +++
 rtl/psg_env_seq.sv | 105 ++++++++++
 tb/tb_psg_env_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// rtl/psg_pkg.sv - shared constants and FSM states for the PSG envelope sequencer
package psg_pkg;

  localparam logic [1:0] ADDR_PER_LO = 2'd0;
  localparam logic [1:0] ADDR_PER_HI = 2'd1;
  localparam logic [1:0] ADDR_SHAPE  = 2'd2;

  localparam int PRESC_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/psg_env_presc.sv
// rtl/psg_env_presc.sv - cen prescaler producing one envelope tick every PRESC cen pulses
module psg_env_presc
  import psg_pkg::*;
#(
  parameter int PRESC = PRESC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(PRESC - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (cen) begin
      count <= (count == LAST) ? 8'd0 : count + 8'd1;
    end
  end

  assign tick = cen && !clr && (count == LAST);

endmodule

// File: rtl/psg_env_seq.sv
// rtl/psg_env_seq.sv - envelope period/shape register block and step sequencer
module psg_env_seq
  import psg_pkg::*;
#(
  parameter int PRESC = PRESC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       step,
  output logic       null_period,
  output logic       restart,
  output logic [3:0] ctrl,
  output logic       busy
);

  state_t      state, state_nx;
  logic [7:0]  per_lo, per_hi;
  logic [15:0] period, period_nx, cnt;
  logic        tick, shape_wr, presc_clr, expiry, pend;

  assign period    = {per_hi, per_lo};
  assign shape_wr  = wr_en && (wr_addr == ADDR_SHAPE);
  assign presc_clr = shape_wr || (state == ST_ARM);
  // cnt may already be past a freshly lowered period; >= makes that expire instead of wrapping
  assign expiry    = (period != 16'd0) && (cnt >= period - 16'd1);
  assign busy      = (state != ST_RUN);

  psg_env_presc #(.PRESC(PRESC)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .clr   (presc_clr),
    .tick  (tick)
  );

  always_comb begin
    period_nx = period;
    if (wr_en && (wr_addr == ADDR_PER_LO)) period_nx[7:0]  = wr_data;
    if (wr_en && (wr_addr == ADDR_PER_HI)) period_nx[15:8] = wr_data;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = ST_IDLE;
      ST_ARM:  state_nx = ST_WAIT;
      ST_WAIT: if (cen) state_nx = ST_RUN;
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_IDLE;
    endcase
    if (shape_wr) state_nx = ST_ARM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_lo      <= '0;
      per_hi      <= '0;
      ctrl        <= '0;
      cnt         <= '0;
      step        <= 1'b0;
      pend        <= 1'b0;
      null_period <= 1'b0;
      restart     <= 1'b0;
    end else begin
      per_lo      <= period_nx[7:0];
      per_hi      <= period_nx[15:8];
      restart     <= (state_nx == ST_ARM);
      null_period <= (state_nx == ST_RUN) && (period_nx == 16'd0);
      if (shape_wr) ctrl <= wr_data[3:0];

      if (shape_wr || (state == ST_ARM)) begin
        cnt  <= '0;
        step <= 1'b0;
        pend <= 1'b0;
      end else if (state != ST_RUN) begin
        step <= 1'b0;
        pend <= 1'b0;
      end else if (tick) begin
        // back-to-back expiries: drop step on the tick, re-raise it one clk later
        cnt  <= expiry ? 16'd0 : cnt + 16'd1;
        pend <= expiry && step;
        step <= expiry && !step;
      end else if (period == 16'd0) begin
        step <= 1'b0;
        pend <= 1'b0;
      end else if (pend) begin
        step <= 1'b1;
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psg_env_seq.sv
// tb/tb_psg_env_seq.sv - directed self-checking bench for psg_env_seq
module tb_psg_env_seq;
  import psg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic       step, null_period, restart, busy;
  logic [3:0] ctrl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psg_env_seq #(.PRESC(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen         (cen),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .step        (step),
    .null_period (null_period),
    .restart     (restart),
    .ctrl        (ctrl),
    .busy        (busy)
  );

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step_clk();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    cen = 1'b0; wr_en = 1'b0; rst_n = 1'b0;
    step_clk();
    step_clk();
    rst_n = 1'b1;
    step_clk();
  endtask

  task automatic test_reset();
    bit seen_step, seen_restart, seen_run;
    seen_step = 0; seen_restart = 0; seen_run = 0;
    rst_n = 1'b0;
    #3;
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL rst_step: got %b want 0", step); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL rst_restart: got %b want 0", restart); end
    checks++; if (null_period !== 1'b0) begin errors++; $display("FAIL rst_null: got %b want 0", null_period); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
    checks++; if (ctrl !== 4'h0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", ctrl); end
    step_clk();
    rst_n = 1'b1;
    cen = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step_clk();
      if (step) seen_step = 1;
      if (restart) seen_restart = 1;
      if (!busy) seen_run = 1;
    end
    write(2'd3, 8'hFF);
    checks++; if (seen_step) begin errors++; $display("FAIL idle_step: got 1 want 0"); end
    checks++; if (seen_restart) begin errors++; $display("FAIL idle_restart: got 1 want 0"); end
    checks++; if (seen_run || busy !== 1'b1) begin errors++; $display("FAIL idle_busy: got %b want 1", busy); end
    checks++; if (ctrl !== 4'h0) begin errors++; $display("FAIL idle_ctrl: got %h want 0", ctrl); end
    cen = 1'b0;
  endtask

  task automatic test_run_period3();
    int edges[8];
    int n_edges, width;
    logic prev;
    n_edges = 0; width = 0;
    for (int i = 0; i < 8; i++) edges[i] = -1;
    do_reset();
    cen = 1'b1;
    write(ADDR_PER_LO, 8'd3);
    write(ADDR_PER_HI, 8'd0);
    checks++; if (busy !== 1'b1 || restart !== 1'b0) begin errors++; $display("FAIL perwr_idle: busy=%b restart=%b want 1/0", busy, restart); end
    write(ADDR_SHAPE, 8'hFE);
    checks++; if (restart !== 1'b1) begin errors++; $display("FAIL arm_restart: got %b want 1", restart); end
    checks++; if (ctrl !== 4'hE) begin errors++; $display("FAIL arm_ctrl: got %h want e", ctrl); end
    step_clk();
    checks++; if (restart !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wait_state: restart=%b busy=%b want 0/1", restart, busy); end
    step_clk();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_busy: got %b want 0", busy); end
    prev = step;
    for (int e = 3; e <= 60; e++) begin
      step_clk();
      if (step && !prev && n_edges < 8) begin edges[n_edges] = e; n_edges++; end
      if (step && e < 49) width++;
      if (restart) begin errors++; checks++; $display("FAIL extra_restart: got 1 want 0 at clk %0d", e); end
      prev = step;
    end
    checks++; if (n_edges !== 2) begin errors++; $display("FAIL p3_edge_count: got %0d want 2", n_edges); end
    checks++; if (edges[0] !== 25) begin errors++; $display("FAIL p3_first_edge: got %0d want 25", edges[0]); end
    checks++; if (edges[1] - edges[0] !== 24) begin errors++; $display("FAIL p3_spacing: got %0d want 24", edges[1] - edges[0]); end
    checks++; if (width !== 8) begin errors++; $display("FAIL p3_width: got %0d want 8", width); end
    write(ADDR_PER_HI, 8'd1);
    checks++; if (busy !== 1'b0 || restart !== 1'b0) begin errors++; $display("FAIL perwr_run: busy=%b restart=%b want 0/0", busy, restart); end
  endtask

  task automatic test_null_period();
    int edges[8];
    int n_edges;
    bit seen_step;
    logic prev;
    n_edges = 0; seen_step = 0;
    for (int i = 0; i < 8; i++) edges[i] = -1;
    do_reset();
    cen = 1'b1;
    write(ADDR_SHAPE, 8'h00);
    step_clk();
    step_clk();
    checks++; if (null_period !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL null_set: null=%b busy=%b want 1/0", null_period, busy); end
    for (int i = 0; i < 40; i++) begin
      step_clk();
      if (step) seen_step = 1;
    end
    checks++; if (seen_step) begin errors++; $display("FAIL null_step: got 1 want 0"); end
    write(ADDR_PER_LO, 8'd1);
    checks++; if (null_period !== 1'b0) begin errors++; $display("FAIL null_clear: got %b want 0", null_period); end
    prev = step;
    for (int e = 1; e <= 40; e++) begin
      step_clk();
      if (step && !prev && n_edges < 8) begin edges[n_edges] = e; n_edges++; end
      prev = step;
    end
    checks++; if (n_edges !== 5) begin errors++; $display("FAIL p1_edge_count: got %0d want 5", n_edges); end
    checks++; if (edges[0] !== 6) begin errors++; $display("FAIL p1_first_edge: got %0d want 6", edges[0]); end
    checks++; if (edges[2] - edges[1] !== 8) begin errors++; $display("FAIL p1_spacing_a: got %0d want 8", edges[2] - edges[1]); end
    checks++; if (edges[3] - edges[2] !== 8) begin errors++; $display("FAIL p1_spacing_b: got %0d want 8", edges[3] - edges[2]); end
  endtask

  task automatic test_lower_period();
    bit early;
    early = 0;
    do_reset();
    cen = 1'b1;
    write(ADDR_PER_LO, 8'd200);
    write(ADDR_SHAPE, 8'h0A);
    for (int i = 0; i < 801; i++) begin
      step_clk();
      if (step) early = 1;
    end
    write(ADDR_PER_LO, 8'd50);
    for (int i = 0; i < 6; i++) begin
      step_clk();
      if (step) early = 1;
    end
    checks++; if (early || step !== 1'b0) begin errors++; $display("FAIL lower_early: got 1 want 0"); end
    step_clk();
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL lower_expiry: got %b want 1", step); end
  endtask

  task automatic test_shape_on_expiry();
    bit seen_step;
    seen_step = 0;
    do_reset();
    cen = 1'b1;
    write(ADDR_PER_LO, 8'd3);
    write(ADDR_SHAPE, 8'h0E);
    for (int i = 0; i < 24; i++) begin
      step_clk();
      if (step) seen_step = 1;
    end
    write(ADDR_SHAPE, 8'h05);
    checks++; if (restart !== 1'b1 || step !== 1'b0) begin errors++; $display("FAIL collide: restart=%b step=%b want 1/0", restart, step); end
    checks++; if (ctrl !== 4'h5) begin errors++; $display("FAIL collide_ctrl: got %h want 5", ctrl); end
    for (int i = 0; i < 15; i++) begin
      step_clk();
      if (step) seen_step = 1;
    end
    checks++; if (seen_step) begin errors++; $display("FAIL collide_step: got 1 want 0"); end
  endtask

  task automatic test_wait_reset();
    do_reset();
    write(ADDR_SHAPE, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (restart !== 1'b0 || ctrl !== 4'h0) begin errors++; $display("FAIL arm_reset: restart=%b ctrl=%h want 0/0", restart, ctrl); end
    step_clk();
    rst_n = 1'b1;
    step_clk();
    write(ADDR_SHAPE, 8'h09);
    step_clk();
    for (int i = 0; i < 3; i++) step_clk();
    checks++; if (busy !== 1'b1 || null_period !== 1'b0) begin errors++; $display("FAIL wait_hold: busy=%b null=%b want 1/0", busy, null_period); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (restart !== 1'b0 || ctrl !== 4'h0 || busy !== 1'b1) begin errors++; $display("FAIL wait_reset: restart=%b ctrl=%h busy=%b want 0/0/1", restart, ctrl, busy); end
    step_clk();
    rst_n = 1'b1;
    step_clk();
    write(ADDR_SHAPE, 8'h01);
    step_clk();
    cen = 1'b1;
    step_clk();
    cen = 1'b0;
    checks++; if (busy !== 1'b0 || null_period !== 1'b1) begin errors++; $display("FAIL wait_to_run: busy=%b null=%b want 0/1", busy, null_period); end
  endtask

  initial begin
    test_reset();
    test_run_period3();
    test_null_period();
    test_lower_period();
    test_shape_on_expiry();
    test_wait_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
